// File: rtl/cv32e40p_mult_ft_ctrl.sv
// Fault-handling sequencer for the triplicated multiplier: withholds voted ready on voter
// disagreement, re-evaluates the held operation, and latches a permanent fault if it persists.
module cv32e40p_mult_ft_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_RETRY     = 3,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_i,
  input  logic             mult_ready_i,
  input  logic [3:0]       error_detected_i,
  input  logic             clear_i,
  output logic             ready_o,
  output logic             retry_o,
  output logic             perm_fault_o,
  output logic             error_irq_o,
  output logic [3:0]       err_sticky_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int WW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(SETTLE_CYCLES - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] RECHECK = 2'd2;
  localparam logic [1:0] FAULT   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [3:0]       sticky_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sampling;
  logic             err_event;
  logic             ready_raw;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Voter flags are only meaningful when the multiplier presents a result.
  assign sampling  = (state_q != WAIT) && enable_i && mult_ready_i;
  assign err_event = sampling && (|error_detected_i);

  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    wait_d      = wait_q;
    ready_raw   = 1'b0;
    retry_o     = 1'b0;
    error_irq_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (err_event) begin
          retry_d = RW'(1);
          wait_d  = '0;
          state_d = WAIT;
        end else begin
          ready_raw = mult_ready_i;
        end
      end
      WAIT: begin
        retry_o = 1'b1;
        if (!enable_i) begin
          state_d = IDLE;
          retry_d = '0;
          wait_d  = '0;
        end else if (wait_q == WAIT_LAST) begin
          state_d = RECHECK;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      RECHECK: begin
        retry_o = 1'b1;
        if (!enable_i) begin
          state_d = IDLE;
          retry_d = '0;
          wait_d  = '0;
        end else if (!mult_ready_i) begin
          state_d = RECHECK;
        end else if (err_event) begin
          if (retry_q == RETRY_LAST) begin
            // Out of retries: release the voted result and give up retrying.
            ready_raw   = mult_ready_i;
            error_irq_o = 1'b1;
            retry_d     = '0;
            state_d     = FAULT;
          end else begin
            retry_d = retry_q + RW'(1);
            wait_d  = '0;
            state_d = WAIT;
          end
        end else begin
          ready_raw = mult_ready_i;
          retry_d   = '0;
          state_d   = IDLE;
        end
      end
      default: begin
        ready_raw = mult_ready_i;
        if (clear_i) begin
          state_d = IDLE;
          retry_d = '0;
          wait_d  = '0;
        end
      end
    endcase
  end

  // The IDLE passthrough must not leak while reset is held.
  assign ready_o      = ready_raw & rst_n;
  assign perm_fault_o = (state_q == FAULT);
  assign err_sticky_o = sticky_q;
  assign err_cnt_o    = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      retry_q <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      wait_q  <= wait_d;
    end
  end

  // A clear coincident with a new event keeps that event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= '0;
      cnt_q    <= '0;
    end else if (clear_i) begin
      sticky_q <= err_event ? error_detected_i : 4'b0000;
      cnt_q    <= err_event ? CNT_W'(1) : '0;
    end else if (err_event) begin
      sticky_q <= sticky_q | error_detected_i;
      cnt_q    <= sat_inc(cnt_q);
    end
  end

endmodule

// File: tb/tb_cv32e40p_mult_ft_ctrl.sv
// Directed bench for cv32e40p_mult_ft_ctrl; a CNT_W=2 copy shares the stimulus for saturation.
module tb_cv32e40p_mult_ft_ctrl;

  logic       clk;
  logic       rst_n;
  logic       enable_i;
  logic       mult_ready_i;
  logic [3:0] error_detected_i;
  logic       clear_i;
  logic       ready_o, retry_o, perm_fault_o, error_irq_o;
  logic [3:0] err_sticky_o;
  logic [7:0] err_cnt_o;
  logic       s_ready_o, s_retry_o, s_perm_fault_o, s_error_irq_o;
  logic [3:0] s_err_sticky_o;
  logic [1:0] s_err_cnt_o;

  int checks;
  int failures;

  cv32e40p_mult_ft_ctrl #(.SETTLE_CYCLES(2), .MAX_RETRY(3), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .mult_ready_i(mult_ready_i),
    .error_detected_i(error_detected_i), .clear_i(clear_i),
    .ready_o(ready_o), .retry_o(retry_o), .perm_fault_o(perm_fault_o),
    .error_irq_o(error_irq_o), .err_sticky_o(err_sticky_o), .err_cnt_o(err_cnt_o)
  );

  cv32e40p_mult_ft_ctrl #(.SETTLE_CYCLES(2), .MAX_RETRY(3), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .mult_ready_i(mult_ready_i),
    .error_detected_i(error_detected_i), .clear_i(clear_i),
    .ready_o(s_ready_o), .retry_o(s_retry_o), .perm_fault_o(s_perm_fault_o),
    .error_irq_o(s_error_irq_o), .err_sticky_o(s_err_sticky_o), .err_cnt_o(s_err_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    enable_i = 1'b0; mult_ready_i = 1'b0; error_detected_i = 4'b0000; clear_i = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    enable_i = 1'b1; mult_ready_i = 1'b1; error_detected_i = 4'b0001; clear_i = 1'b0;
    #7;
    checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b want=0", ready_o); end
    checks++; if (retry_o !== 1'b0) begin failures++; $display("FAIL reset_retry got=%b want=0", retry_o); end
    checks++; if (perm_fault_o !== 1'b0) begin failures++; $display("FAIL reset_perm got=%b want=0", perm_fault_o); end
    checks++; if (error_irq_o !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b want=0", error_irq_o); end
    checks++; if (err_sticky_o !== 4'b0000) begin failures++; $display("FAIL reset_sticky got=%b want=0000", err_sticky_o); end
    checks++; if (err_cnt_o !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0d want=0", err_cnt_o); end
    @(posedge clk); #1;
    enable_i = 1'b0; mult_ready_i = 1'b0; error_detected_i = 4'b0000;
    rst_n = 1'b1;
  endtask

  task automatic test_clean();
    apply_reset();
    enable_i = 1'b1; mult_ready_i = 1'b1; error_detected_i = 4'b0000;
    #4;
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL clean_ready got=%b want=1", ready_o); end
    checks++; if (retry_o !== 1'b0) begin failures++; $display("FAIL clean_retry got=%b want=0", retry_o); end
    step();
    mult_ready_i = 1'b0;
    #4;
    checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL clean_notready got=%b want=0", ready_o); end
    checks++; if (err_cnt_o !== 8'd0) begin failures++; $display("FAIL clean_cnt got=%0d want=0", err_cnt_o); end
    step();
  endtask

  task automatic test_transient();
    logic [4:0] exp_rdy;
    logic [4:0] exp_rty;
    exp_rdy = 5'b11000;
    exp_rty = 5'b01110;
    apply_reset();
    enable_i = 1'b1; mult_ready_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      error_detected_i = (c == 0) ? 4'b0001 : 4'b0000;
      #4;
      checks++; if (ready_o !== exp_rdy[c]) begin failures++; $display("FAIL transient_ready c=%0d got=%b want=%b", c, ready_o, exp_rdy[c]); end
      checks++; if (retry_o !== exp_rty[c]) begin failures++; $display("FAIL transient_retry c=%0d got=%b want=%b", c, retry_o, exp_rty[c]); end
      step();
    end
    checks++; if (err_cnt_o !== 8'd1) begin failures++; $display("FAIL transient_cnt got=%0d want=1", err_cnt_o); end
    checks++; if (err_sticky_o !== 4'b0001) begin failures++; $display("FAIL transient_sticky got=%b want=0001", err_sticky_o); end
  endtask

  task automatic test_persistent();
    logic [10:0] exp_rdy;
    logic [10:0] exp_rty;
    logic [10:0] exp_irq;
    logic [10:0] exp_prm;
    exp_rdy = 11'b110_0000_0000;
    exp_rty = 11'b011_1111_1110;
    exp_irq = 11'b010_0000_0000;
    exp_prm = 11'b100_0000_0000;
    apply_reset();
    enable_i = 1'b1; mult_ready_i = 1'b1; error_detected_i = 4'b0001;
    for (int c = 0; c < 11; c++) begin
      #4;
      checks++; if (ready_o !== exp_rdy[c]) begin failures++; $display("FAIL persist_ready c=%0d got=%b want=%b", c, ready_o, exp_rdy[c]); end
      checks++; if (retry_o !== exp_rty[c]) begin failures++; $display("FAIL persist_retry c=%0d got=%b want=%b", c, retry_o, exp_rty[c]); end
      checks++; if (error_irq_o !== exp_irq[c]) begin failures++; $display("FAIL persist_irq c=%0d got=%b want=%b", c, error_irq_o, exp_irq[c]); end
      checks++; if (perm_fault_o !== exp_prm[c]) begin failures++; $display("FAIL persist_perm c=%0d got=%b want=%b", c, perm_fault_o, exp_prm[c]); end
      if (c == 10) begin
        checks++; if (err_cnt_o !== 8'd4) begin failures++; $display("FAIL persist_cnt got=%0d want=4", err_cnt_o); end
      end
      step();
    end
    error_detected_i = 4'b0000; clear_i = 1'b1;
    #4;
    checks++; if (err_cnt_o !== 8'd5) begin failures++; $display("FAIL fault_counts got=%0d want=5", err_cnt_o); end
    step();
    clear_i = 1'b0;
    #4;
    checks++; if (perm_fault_o !== 1'b0) begin failures++; $display("FAIL clear_perm got=%b want=0", perm_fault_o); end
    checks++; if (err_cnt_o !== 8'd0) begin failures++; $display("FAIL clear_cnt got=%0d want=0", err_cnt_o); end
    checks++; if (err_sticky_o !== 4'b0000) begin failures++; $display("FAIL clear_sticky got=%b want=0000", err_sticky_o); end
    checks++; if (ready_o !== 1'b1 || retry_o !== 1'b0) begin failures++; $display("FAIL clear_idle got=%b%b want=10", ready_o, retry_o); end
    step();
  endtask

  task automatic test_flush();
    apply_reset();
    enable_i = 1'b1; mult_ready_i = 1'b1; error_detected_i = 4'b0010;
    step();
    enable_i = 1'b0; mult_ready_i = 1'b0; error_detected_i = 4'b0000;
    #4;
    checks++; if (retry_o !== 1'b1) begin failures++; $display("FAIL flush_wait_retry got=%b want=1", retry_o); end
    step();
    #4;
    checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b want=0", ready_o); end
    checks++; if (retry_o !== 1'b0) begin failures++; $display("FAIL flush_retry got=%b want=0", retry_o); end
    checks++; if (err_cnt_o !== 8'd1) begin failures++; $display("FAIL flush_cnt got=%0d want=1", err_cnt_o); end
    step();
    enable_i = 1'b1; mult_ready_i = 1'b1;
    #4;
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL flush_idle_ready got=%b want=1", ready_o); end
    step();
  endtask

  task automatic test_recheck_stall();
    apply_reset();
    enable_i = 1'b1; mult_ready_i = 1'b1; error_detected_i = 4'b0100;
    step();
    error_detected_i = 4'b0000;
    step(); step();
    mult_ready_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #4;
      checks++; if (ready_o !== 1'b0 || retry_o !== 1'b1) begin failures++; $display("FAIL stall_hold c=%0d got=%b%b want=01", c, ready_o, retry_o); end
      step();
    end
    mult_ready_i = 1'b1;
    #4;
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL stall_release got=%b want=1", ready_o); end
    step();
    #4;
    checks++; if (retry_o !== 1'b0 || err_cnt_o !== 8'd1) begin failures++; $display("FAIL stall_idle retry=%b cnt=%0d want retry=0 cnt=1", retry_o, err_cnt_o); end
    step();
  endtask

  task automatic test_saturation();
    apply_reset();
    enable_i = 1'b1; mult_ready_i = 1'b1; error_detected_i = 4'b0001;
    repeat (15) step();
    #4;
    checks++; if (err_cnt_o !== 8'd9) begin failures++; $display("FAIL sat_wide_cnt got=%0d want=9", err_cnt_o); end
    checks++; if (s_err_cnt_o !== 2'd3) begin failures++; $display("FAIL sat_narrow_cnt got=%0d want=3", s_err_cnt_o); end
    checks++; if (s_perm_fault_o !== 1'b1) begin failures++; $display("FAIL sat_perm got=%b want=1", s_perm_fault_o); end
    clear_i = 1'b1; error_detected_i = 4'b1000;
    step();
    clear_i = 1'b0; error_detected_i = 4'b0000;
    #4;
    checks++; if (s_err_cnt_o !== 2'd1) begin failures++; $display("FAIL prio_cnt got=%0d want=1", s_err_cnt_o); end
    checks++; if (s_err_sticky_o !== 4'b1000) begin failures++; $display("FAIL prio_sticky got=%b want=1000", s_err_sticky_o); end
    checks++; if (err_cnt_o !== 8'd1) begin failures++; $display("FAIL prio_wide_cnt got=%0d want=1", err_cnt_o); end
    checks++; if (perm_fault_o !== 1'b0) begin failures++; $display("FAIL prio_perm got=%b want=0", perm_fault_o); end
    step();
  endtask

  task automatic test_async_reset();
    apply_reset();
    enable_i = 1'b1; mult_ready_i = 1'b1; error_detected_i = 4'b0001;
    step();
    error_detected_i = 4'b0000;
    #2;
    checks++; if (retry_o !== 1'b1 || err_cnt_o !== 8'd1) begin failures++; $display("FAIL areset_pre retry=%b cnt=%0d want retry=1 cnt=1", retry_o, err_cnt_o); end
    rst_n = 1'b0;
    #1;
    checks++; if (retry_o !== 1'b0) begin failures++; $display("FAIL areset_retry got=%b want=0", retry_o); end
    checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL areset_ready got=%b want=0", ready_o); end
    checks++; if (err_cnt_o !== 8'd0 || err_sticky_o !== 4'b0000) begin failures++; $display("FAIL areset_status cnt=%0d sticky=%b want 0", err_cnt_o, err_sticky_o); end
    #3;
    rst_n = 1'b1;
    step();
    #4;
    checks++; if (ready_o !== 1'b1 || retry_o !== 1'b0) begin failures++; $display("FAIL areset_idle got=%b%b want=10", ready_o, retry_o); end
    step();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    enable_i = 1'b0; mult_ready_i = 1'b0; error_detected_i = 4'b0000; clear_i = 1'b0;
    test_reset();
    test_clean();
    test_transient();
    test_persistent();
    test_flush();
    test_recheck_stall();
    test_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
